// File: rtl/alu_pipe_if.sv
// -----------------------------------------------------------------------------
// alu_pipe_if
// Handshake/operand bundle between a producer, the alu_pipe block and a
// consumer.
//   in_valid/in_ready   : request handshake (producer -> ALU)
//   opa/opb/opcode      : operands and operation, sampled at accept
//   out_valid/out_ready : result handshake (ALU -> consumer)
//   out, flag_z/c/v/n   : result and status flags
// Modports: master = producer/consumer side, slave = the ALU.
// -----------------------------------------------------------------------------
interface alu_pipe_if #(
    parameter int N = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] opa;
    logic [N-1:0] opb;
    logic [2:0]   opcode;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out;
    logic         flag_z;
    logic         flag_c;
    logic         flag_v;
    logic         flag_n;

    modport master (
        output in_valid, opa, opb, opcode, out_ready,
        input  in_ready, out_valid, out, flag_z, flag_c, flag_v, flag_n
    );

    modport slave (
        input  in_valid, opa, opb, opcode, out_ready,
        output in_ready, out_valid, out, flag_z, flag_c, flag_v, flag_n
    );
endinterface

// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
// Registered N-bit ALU with valid/ready flow control. ADD/SUB/AND/OR/XOR/
// SHL/SHR complete at the accept edge; MUL runs an N-step shift-add loop.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : alu_pipe_if.slave (operands, opcode, result, flags, handshakes)
// -----------------------------------------------------------------------------
module alu_pipe #(
    parameter int N = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_pipe_if.slave  bus
);
    localparam int SW = $clog2(N);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [N-1:0]   r_out;
    logic           r_z, r_c, r_v, r_n;
    logic [2*N-1:0] r_mcand;     // multiplicand, pre-shifted by the iteration count
    logic [N-1:0]   r_mplier;    // multiplier, shifted right so bit 0 is the current bit
    logic [2*N-1:0] r_acc;
    logic [SW-1:0]  r_cnt;

    logic           w_in_ready;
    logic           w_accept;
    logic           w_is_mul;
    logic           w_last_iter;
    logic [2*N-1:0] w_acc_nxt;
    logic [N:0]     w_sum;
    logic [N:0]     w_diff;
    logic [N-1:0]   w_res;
    logic           w_c;
    logic           w_v;

    // In DONE the slot frees up in the same cycle the consumer takes the result.
    assign w_in_ready  = (r_state == IDLE) || ((r_state == DONE) && bus.out_ready);
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_is_mul    = (bus.opcode == OP_MUL);
    assign w_last_iter = (r_cnt == SW'(N-1));
    assign w_acc_nxt   = r_acc + (r_mplier[0] ? r_mcand : {(2*N){1'b0}});

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == DONE);
    assign bus.out       = r_out;
    assign bus.flag_z    = r_z;
    assign bus.flag_c    = r_c;
    assign bus.flag_v    = r_v;
    assign bus.flag_n    = r_n;

    // Single-cycle operation result and carry/overflow for the current opcode.
    always_comb begin
        w_sum  = {1'b0, bus.opa} + {1'b0, bus.opb};
        w_diff = {1'b0, bus.opa} - {1'b0, bus.opb};
        w_res  = {N{1'b0}};
        w_c    = 1'b0;
        w_v    = 1'b0;
        case (bus.opcode)
            OP_ADD: begin
                w_res = w_sum[N-1:0];
                w_c   = w_sum[N];
                w_v   = (bus.opa[N-1] == bus.opb[N-1]) && (w_sum[N-1] != bus.opa[N-1]);
            end
            OP_SUB: begin
                w_res = w_diff[N-1:0];
                w_c   = w_diff[N];   // borrow out of the top bit == (opa < opb)
                w_v   = (bus.opa[N-1] != bus.opb[N-1]) && (w_diff[N-1] != bus.opa[N-1]);
            end
            OP_AND:  w_res = bus.opa & bus.opb;
            OP_OR:   w_res = bus.opa | bus.opb;
            OP_XOR:  w_res = bus.opa ^ bus.opb;
            OP_SHL:  w_res = bus.opa << bus.opb[SW-1:0];
            OP_SHR:  w_res = bus.opa >> bus.opb[SW-1:0];
            default: w_res = {N{1'b0}};
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; an accept in DONE behaves exactly like one in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_is_mul ? BUSY : DONE;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            BUSY: begin
                if (w_last_iter) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = BUSY;
                end
            end
            DONE: begin
                if (w_accept) begin
                    w_state_nxt = w_is_mul ? BUSY : DONE;
                end else if (bus.out_ready) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Result/flag registers and the shift-add multiplier datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out    <= {N{1'b0}};
            r_z      <= 1'b0;
            r_c      <= 1'b0;
            r_v      <= 1'b0;
            r_n      <= 1'b0;
            r_mcand  <= {(2*N){1'b0}};
            r_mplier <= {N{1'b0}};
            r_acc    <= {(2*N){1'b0}};
            r_cnt    <= {SW{1'b0}};
        end else if (w_accept) begin
            if (w_is_mul) begin
                r_mcand  <= {{N{1'b0}}, bus.opa};
                r_mplier <= bus.opb;
                r_acc    <= {(2*N){1'b0}};
                r_cnt    <= {SW{1'b0}};
            end else begin
                r_out <= w_res;
                r_z   <= (w_res == {N{1'b0}});
                r_c   <= w_c;
                r_v   <= w_v;
                r_n   <= w_res[N-1];
            end
        end else if (r_state == BUSY) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            // The final iteration writes the product straight into the result.
            if (w_last_iter) begin
                r_out <= w_acc_nxt[N-1:0];
                r_z   <= (w_acc_nxt[N-1:0] == {N{1'b0}});
                r_c   <= |w_acc_nxt[2*N-1:N];
                r_v   <= 1'b0;
                r_n   <= w_acc_nxt[N-1];
            end
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;
    localparam int N = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_pipe_if #(.N(N)) bus ();

    alu_pipe #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {z, c, v, n, out[7:0]} from plain integer arithmetic.
    function automatic logic [11:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int ua, ub, sa, sb, r, res;
        logic c, v;
        ua = a; ub = b;
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        c = 1'b0; v = 1'b0; res = 0;
        case (op)
            3'd0: begin r = ua + ub; res = r % 256; c = (r >= 256);
                        v = ((sa + sb) > 127) || ((sa + sb) < -128); end
            3'd1: begin res = (ua - ub + 256) % 256; c = (ua < ub);
                        v = ((sa - sb) > 127) || ((sa - sb) < -128); end
            3'd2: res = ua & ub;
            3'd3: res = ua | ub;
            3'd4: res = ua ^ ub;
            3'd5: res = (ua * (1 << (ub % 8))) % 256;
            3'd6: res = ua / (1 << (ub % 8));
            3'd7: begin r = ua * ub; res = r % 256; c = (r >= 256); end
            default: res = 0;
        endcase
        return {(res == 0), c, v, (res >= 128), 8'(res)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_result(input string tag, input logic [11:0] e);
        chk({tag, "_out"}, 32'(bus.out), 32'(e[7:0]));
        chk({tag, "_z"},   32'(bus.flag_z), 32'(e[11]));
        chk({tag, "_c"},   32'(bus.flag_c), 32'(e[10]));
        chk({tag, "_v"},   32'(bus.flag_v), 32'(e[9]));
        chk({tag, "_n"},   32'(bus.flag_n), 32'(e[8]));
    endtask

    // One complete transaction with out_ready=1; checks latency, BUSY in_ready and result.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int cycles;
        logic [11:0] e;
        e = model(op, a, b);
        bus.opcode = op; bus.opa = a; bus.opb = b;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.opa = ~a; bus.opb = ~b; bus.opcode = 3'(op + 3'd1);   // must be ignored now
        cycles = 1;
        while (!bus.out_valid && cycles < 50) begin
            if (op == 3'd7) chk({tag, "_busy_in_ready"}, 32'(bus.in_ready), 32'd0);
            tick();
            cycles++;
        end
        chk({tag, "_latency"}, 32'(cycles), (op == 3'd7) ? 32'(N + 1) : 32'd1);
        chk_result(tag, e);
        tick();
        chk({tag, "_drop_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_hold_out"}, 32'(bus.out), 32'(e[7:0]));
    endtask

    initial begin
        logic [2:0]  op;
        logic [7:0]  a, b;
        logic [11:0] e;
        checks = 0; errors = 0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.opa = 8'd0; bus.opb = 8'd0; bus.opcode = 3'd0;
        rst_n = 1'b0;
        #12;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out", 32'(bus.out), 32'd0);
        chk("rst_flags", 32'({bus.flag_z, bus.flag_c, bus.flag_v, bus.flag_n}), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Directed test-plan cases, with literal expectations alongside the model.
        do_op("add17_9", 3'd0, 8'd17, 8'd9);    chk("tp_add17_9", 32'(bus.out), 32'd26);
        do_op("sub17_9", 3'd1, 8'd17, 8'd9);    chk("tp_sub17_9", 32'(bus.out), 32'd8);
        do_op("sub9_17", 3'd1, 8'd9, 8'd17);    chk("tp_sub9_17", 32'({bus.out, bus.flag_c, bus.flag_n, bus.flag_v}), 32'({8'd248, 3'b110}));
        do_op("add200_100", 3'd0, 8'd200, 8'd100); chk("tp_add200_100", 32'({bus.out, bus.flag_c, bus.flag_v}), 32'({8'd44, 2'b10}));
        do_op("add100_100", 3'd0, 8'd100, 8'd100); chk("tp_add100_100", 32'({bus.out, bus.flag_c, bus.flag_v, bus.flag_n}), 32'({8'd200, 3'b011}));
        do_op("xor55", 3'd4, 8'h55, 8'h55);     chk("tp_xor_z", 32'(bus.flag_z), 32'd1);
        do_op("mul17_9", 3'd7, 8'd17, 8'd9);    chk("tp_mul17_9", 32'({bus.out, bus.flag_c}), 32'({8'd153, 1'b0}));
        do_op("mul17_16", 3'd7, 8'd17, 8'd16);  chk("tp_mul17_16", 32'({bus.out, bus.flag_c}), 32'({8'd16, 1'b1}));
        do_op("shr_max", 3'd6, 8'h80, 8'hFF);   chk("tp_shr7", 32'(bus.out), 32'd1);
        do_op("mul255", 3'd7, 8'd255, 8'd255);

        // Backpressure: result held, pending request blocked, then back-to-back accept.
        bus.opcode = 3'd5; bus.opa = 8'h81; bus.opb = 8'd1;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        tick();
        bus.opcode = 3'd3; bus.opa = 8'd17; bus.opb = 8'd9;   // held request
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_out", 32'(bus.out), 32'h02);
            chk("bp_c", 32'(bus.flag_c), 32'd0);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("bp_b2b_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_b2b_out", 32'(bus.out), 32'd25);
        tick();
        chk("bp_idle", 32'(bus.out_valid), 32'd0);

        // Randomized full transactions, MUL included.
        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(0, 7));
            a = 8'($urandom); b = 8'($urandom);
            do_op("rand", op, a, b);
        end

        // Randomized back-to-back single-cycle stream: one result per cycle.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            op = 3'($urandom_range(0, 6));
            a = 8'($urandom); b = 8'($urandom);
            e = model(op, a, b);
            bus.opcode = op; bus.opa = a; bus.opb = b; bus.in_valid = 1'b1;
            chk("stream_in_ready", 32'(bus.in_ready), 32'd1);
            tick();
            chk("stream_valid", 32'(bus.out_valid), 32'd1);
            chk_result("stream", e);
        end
        bus.in_valid = 1'b0;
        tick();

        // Reset in the middle of a multiply.
        do_op("pre_rst", 3'd3, 8'hF0, 8'h0F);
        bus.opcode = 3'd7; bus.opa = 8'd200; bus.opb = 8'd3; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("mid_mul_busy", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", 32'(bus.out_valid), 32'd0);
        chk("mrst_out", 32'(bus.out), 32'd0);
        chk("mrst_flags", 32'({bus.flag_z, bus.flag_c, bus.flag_v, bus.flag_n}), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("mrst_in_ready", 32'(bus.in_ready), 32'd1);
        do_op("add1_1", 3'd0, 8'd1, 8'd1);
        chk("tp_add1_1", 32'(bus.out), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, registered N-bit ALU with valid/ready handshakes on input and output, status flags, shifts, and an iterative shift-add multiplier. Successor to the combinational 3-bit-opcode ALU: same opa/opb/opcode operand model, now clocked and flow-controlled so it can sit in a streaming datapath between producer and consumer stages. Single-cycle ops return after one cycle. MUL takes N cycles.

Parameters:
N, 8, operand/result width; power of two, 4..32
SW, $clog2(N), shift-amount width (derived localparam, not overridable)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands/opcode valid
in_ready  output  1  block can accept a new operation
opa  input  N  operand A
opb  input  N  operand B
opcode  input  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL
out_valid  output  1  result/flags valid
out_ready  input  1  consumer accepts result
out  output  N  result
flag_z  output  1  out == 0
flag_c  output  1  carry/borrow/MUL high-half-nonzero
flag_v  output  1  signed overflow (ADD/SUB only)
flag_n  output  1  out[N-1]

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset, asserted at any time including mid-MUL: state=IDLE; out, all flags, out_valid = 0; multiplier registers = 0; in_ready = 1 after release.
- Handshakes:
  - Input transfer when in_valid && in_ready at a rising edge.
  - Output transfer when out_valid && out_ready.
  - out and flags are stable while out_valid && !out_ready.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - On accept of a non-MUL op: compute, register out/flags, go to DONE.
  - On accept of MUL: latch opa/opb, clear the 2N-bit accumulator, count=0, go to BUSY.
- BUSY:
  - in_ready = 0.
  - Each cycle: if multiplier LSB is set, acc += multiplicand << count; count++.
  - After the N-th iteration: out = acc[N-1:0], flag_c = |acc[2N-1:N], go to DONE.
- DONE:
  - out_valid = 1. in_ready = out_ready, so back-to-back operation is allowed.
  - On out_ready with no new accept: go to IDLE, out_valid = 0 next cycle; out/flags hold their last values.
  - On out_ready with simultaneous accept: behave as IDLE-accept in the same edge. A new non-MUL result appears the next cycle with out_valid staying 1; MUL goes to BUSY.
- Latency (accept edge t):
  - Non-MUL: out_valid high after edge t+1.
  - MUL: out_valid high after edge t+N+1.
  - Throughput: 1 op/cycle for non-MUL under continuous out_ready.
- Arithmetic (all widths mod 2^N):
  - ADD: {c,out} = opa+opb; flag_v = (opa[N-1]==opb[N-1]) && (out[N-1]!=opa[N-1]).
  - SUB: out = opa-opb; flag_c = borrow = (opa < opb) unsigned; flag_v = (opa[N-1]!=opb[N-1]) && (out[N-1]!=opa[N-1]).
  - AND/OR/XOR: bitwise; flag_c = flag_v = 0.
  - SHL/SHR: shift amount = opb[SW-1:0]; logical, zero-fill; flag_c = flag_v = 0.
  - MUL: unsigned; flag_v = 0.
  - flag_z and flag_n are derived from the registered out for every op.
- Opcode and operands are sampled only at accept; changes while BUSY are ignored.
- in_valid with in_ready=0: no accept. The producer must hold the request.

Test Plan:
N=8, ADD 17+9, out_ready=1 -> out=26, z=0 c=0 v=0 n=0, out_valid 1 cycle after accept.
SUB 17-9 then SUB 9-17 -> 8 (c=0); 248 (c=1, n=1, v=0).
ADD 200+100 -> 44, c=1, v=0; ADD 100+100 -> 200, c=0, v=1, n=1; XOR 0x55^0x55 -> 0, z=1.
MUL 17*9 -> 153, c=0, out_valid exactly 9 cycles after accept, in_ready=0 during BUSY; MUL 17*16 -> 16, c=1.
Backpressure: SHL 0x81 by 1 with out_ready=0 for 5 cycles -> out=0x02 held stable, in_ready=0, no second op accepted; release out_ready with in_valid=1 OR 17|9 -> out=25 next cycle, out_valid stays 1.
Reset mid-MUL (rst_n low at cycle 4 of BUSY) -> out=0, flags=0, out_valid=0 immediately; after release in_ready=1 and ADD 1+1 -> 2.
